// File: rtl/pipe_rc_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_rc_adder_pkg : shared constants for the pipelined ripple adder  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipe_rc_adder_pkg;

  localparam int unsigned c_def_width  = 16;
  localparam int unsigned c_def_stages = 4;

  // Operation select carried on the sub pin
  localparam logic c_mode_add = 1'b0;
  localparam logic c_mode_sub = 1'b1;

endpackage : pipe_rc_adder_pkg
`default_nettype wire

// File: rtl/pipe_rc_adder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_rc_adder_if : operand and result valid/ready channels           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pipe_rc_adder_if
  import pipe_rc_adder_pkg::*;
#(
  parameter int WIDTH = c_def_width
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface : pipe_rc_adder_if
`default_nettype wire

// File: rtl/pipe_rc_adder_rca_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rca_slice : CHUNK-bit combinational ripple-carry adder               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rca_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             ci_i,
  output logic [CHUNK-1:0] s_o,
  output logic             co_o,
  output logic             c_msb_in_o
);

  always_comb begin : p_ripple
    logic c;
    c          = ci_i;
    s_o        = '0;
    c_msb_in_o = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb_in_o = c;
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    co_o = c;
  end

endmodule : rca_slice
`default_nettype wire

// File: rtl/pipe_rc_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_rc_adder : STAGES-deep skewed ripple-carry add/sub pipeline     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_rc_adder
  import pipe_rc_adder_pkg::*;
#(
  parameter int WIDTH  = c_def_width,
  parameter int STAGES = c_def_stages
) (
  input  logic           clk,
  input  logic           rst,
  pipe_rc_adder_if.slave add_if
);

  localparam int c_stg   = (STAGES < 1) ? 1 : STAGES;
  localparam int c_chunk = WIDTH / c_stg;

  if ((STAGES < 1) || ((WIDTH % c_stg) != 0)) begin : g_param_check
    $error("pipe_rc_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic [c_stg-1:0] vld;
  logic [c_stg-1:0] rdy;

  // A stage can take a beat when empty or when its occupant moves on this cycle
  always_comb begin : p_ready
    logic down_rdy;
    down_rdy = add_if.out_ready;
    rdy      = '0;
    for (int k = c_stg - 1; k >= 0; k--) begin
      rdy[k]   = !vld[k] || down_rdy;
      down_rdy = rdy[k];
    end
  end

  assign add_if.in_ready = rdy[0];

  for (genvar k = 0; k < c_stg; k++) begin : g_stage
    localparam int c_rem = WIDTH - k * c_chunk;

    logic [c_rem-1:0]           a_in;
    logic [c_rem-1:0]           b_in;
    logic                       c_in;
    logic                       v_in;
    logic                       load;
    logic [c_chunk-1:0]         s_d;
    logic                       co_d;
    logic                       cm_d;
    logic [(k+1)*c_chunk-1:0]   sum_d;
    logic [(k+1)*c_chunk-1:0]   sum_q;
    logic                       valid_q;
    logic                       carry_q;

    if (k == 0) begin : g_head
      assign a_in  = add_if.a;
      assign b_in  = (add_if.sub == c_mode_sub) ? ~add_if.b : add_if.b;
      assign c_in  = (add_if.sub == c_mode_sub) ? 1'b1 : add_if.cin;
      assign v_in  = add_if.in_valid;
      assign sum_d = s_d;
    end else begin : g_body
      assign a_in  = g_stage[k-1].g_fwd.a_q;
      assign b_in  = g_stage[k-1].g_fwd.b_q;
      assign c_in  = g_stage[k-1].carry_q;
      assign v_in  = g_stage[k-1].valid_q;
      assign sum_d = {s_d, g_stage[k-1].sum_q};
    end

    assign load   = rdy[k] && v_in;
    assign vld[k] = valid_q;

    rca_slice #(
      .CHUNK(c_chunk)
    ) u_slice (
      .a_i        (a_in[c_chunk-1:0]),
      .b_i        (b_in[c_chunk-1:0]),
      .ci_i       (c_in),
      .s_o        (s_d),
      .co_o       (co_d),
      .c_msb_in_o (cm_d)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else begin
        if (rdy[k]) valid_q <= v_in;
        if (load) begin
          carry_q <= co_d;
          sum_q   <= sum_d;
        end
      end
    end

    // Operand bits not yet consumed travel with the partial sum
    if (k < c_stg - 1) begin : g_fwd
      logic [c_rem-c_chunk-1:0] a_q;
      logic [c_rem-c_chunk-1:0] b_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load) begin
          a_q <= a_in[c_rem-1:c_chunk];
          b_q <= b_in[c_rem-1:c_chunk];
        end
      end
    end

    if (k == c_stg - 1) begin : g_tail
      logic ovf_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else if (load) ovf_q <= co_d ^ cm_d;
      end
      assign add_if.out_valid = valid_q;
      assign add_if.sum       = sum_q;
      assign add_if.cout      = carry_q;
      assign add_if.ovf       = ovf_q;
    end else begin : g_mid
      logic unused_msb_c;
      assign unused_msb_c = cm_d;
    end
  end

endmodule : pipe_rc_adder
`default_nettype wire
